// File: rtl/mdu_pkg.sv
// Shared M-extension definitions: control codes used by the mul/div/ALU decode
// and the divider state encoding.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] DIV  = 4'b0100;
    localparam logic [3:0] DIVU = 4'b0101;
    localparam logic [3:0] REM  = 4'b0110;
    localparam logic [3:0] REMU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdiv_state_e;

    function automatic logic ctrl_is_div_op(input logic [3:0] c);
        return (c == DIV) || (c == DIVU) || (c == REM) || (c == REMU);
    endfunction

    function automatic logic ctrl_is_signed(input logic [3:0] c);
        return (c == DIV) || (c == REM);
    endfunction

    function automatic logic ctrl_is_rem(input logic [3:0] c);
        return (c == REM) || (c == REMU);
    endfunction

endpackage

// File: rtl/mdiv_seq_if.sv
// Pipeline-controller <-> divider handshake: start/kill/operands in,
// busy/valid/result out.
interface mdiv_seq_if;
    import mdu_pkg::*;

    logic            i_start;
    logic            i_kill;
    logic [3:0]      i_ctrl;
    logic [XLEN-1:0] i_dataa;
    logic [XLEN-1:0] i_datab;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start, i_kill, i_ctrl, i_dataa, i_datab,
        input  o_busy, o_valid, o_result
    );

    modport slave (
        input  i_start, i_kill, i_ctrl, i_dataa, i_datab,
        output o_busy, o_valid, o_result
    );

endinterface

// File: rtl/mdiv_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and emit the quotient bit.
module mdiv_step
    import mdu_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            q_bit_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          ge;
    logic          unused_rem_msb;

    // The held remainder is always below the divisor, so its top bit is
    // dropped by the shift; the 33rd bit only matters in the shifted value.
    assign unused_rem_msb = rem_i[XLEN];

    assign rem_sh  = {rem_i[XLEN-1:0], dvd_i[XLEN-1]};
    assign ge      = rem_sh >= {1'b0, dvs_i};
    assign diff    = rem_sh - {1'b0, dvs_i};
    assign rem_o   = ge ? diff : rem_sh;
    assign dvd_o   = {dvd_i[XLEN-2:0], 1'b0};
    assign q_bit_o = ge;

endmodule

// File: rtl/mdiv_seq.sv
// Sequential RV32M divider: DIV/DIVU/REM/REMU in 32 restoring iterations
// plus a sign-fix cycle; divide-by-zero and signed overflow finish at once.
module mdiv_seq
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mdiv_seq_if.slave  bus
);

    mdiv_state_e     state_q, state_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            isrem_q, isrem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_dvd;
    logic            step_q;

    logic            acc_signed;
    logic            acc_rem;
    logic            sa, sb;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    mdiv_step u_step (
        .rem_i   (rem_q),
        .dvd_i   (dvd_q),
        .dvs_i   (dvs_q),
        .rem_o   (step_rem),
        .dvd_o   (step_dvd),
        .q_bit_o (step_q)
    );

    assign acc_signed = ctrl_is_signed(bus.i_ctrl);
    assign acc_rem    = ctrl_is_rem(bus.i_ctrl);
    assign sa         = acc_signed & bus.i_dataa[XLEN-1];
    assign sb         = acc_signed & bus.i_datab[XLEN-1];
    assign div_zero   = (bus.i_datab == '0);
    assign sgn_ovf    = acc_signed && (bus.i_dataa == {1'b1, {(XLEN-1){1'b0}}})
                                   && (bus.i_datab == '1);

    assign quo_fix = negq_q ? -quo_q : quo_q;
    assign rem_fix = negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        isrem_d  = isrem_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_kill && ctrl_is_div_op(bus.i_ctrl)) begin
                    isrem_d = acc_rem;
                    if (div_zero) begin
                        result_d = acc_rem ? bus.i_dataa : '1;
                        state_d  = ST_DONE;
                    end else if (sgn_ovf) begin
                        result_d = acc_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = ST_DONE;
                    end else begin
                        // |0x80000000| stays 0x80000000, which reads correctly as unsigned.
                        negq_d  = sa ^ sb;
                        negr_d  = sa;
                        dvd_d   = sa ? -bus.i_dataa : bus.i_dataa;
                        dvs_d   = sb ? -bus.i_datab : bus.i_datab;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                quo_d = {quo_q[XLEN-2:0], step_q};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = isrem_q ? rem_fix : quo_fix;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush abandons whatever is in flight and leaves the last result alone.
        if (bus.i_kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            isrem_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            isrem_q  <= isrem_d;
            result_q <= result_d;
        end
    end

    assign bus.o_busy   = (state_q != ST_IDLE);
    assign bus.o_valid  = (state_q == ST_DONE);
    assign bus.o_result = result_q;

endmodule

// File: tb/tb_mdiv_seq.sv
// Scoreboard bench for mdiv_seq: expected results are queued at issue and
// compared, with latency, when o_valid fires.
module tb_mdiv_seq;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mdiv_seq_if bus();

    mdiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.i_start = 1'b0;
        bus.i_kill  = 1'b0;
        bus.i_ctrl  = 4'b0000;
        bus.i_dataa = '0;
        bus.i_datab = '0;
    endtask

    // Returns 1 ns after the accept edge.
    task automatic drive_start(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_ctrl  = c;
        bus.i_dataa = a;
        bus.i_datab = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    // inject_at > 0 fires a DIV 50/5 start that many edges into the operation.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input int inject_at);
        int n;
        sb_q.push_back(exp);
        drive_start(c, a, b);
        n = 1;
        while (!bus.o_valid && n < 60) begin
            if (n == inject_at) begin
                bus.i_start = 1'b1;
                bus.i_ctrl  = DIV;
                bus.i_dataa = 32'd50;
                bus.i_datab = 32'd5;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            n++;
        end
        if (!bus.o_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            chk({tag, "_lat"}, n, lat);
            chk({tag, "_res"}, bus.o_result, sb_q.pop_front());
            last_exp = exp;
        end
        // A start during DONE must not be taken.
        bus.i_start = 1'b1;
        bus.i_ctrl  = DIVU;
        bus.i_dataa = 32'd9;
        bus.i_datab = 32'd3;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk({tag, "_done_busy"}, bus.o_busy, 1'b0);
        chk({tag, "_done_valid"}, bus.o_valid, 1'b0);
    endtask

    initial begin
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div_by0",  DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        drive_start(4'b0000, 32'd100, 32'd7);
        chk("bad_ctrl_busy", bus.o_busy, 1'b0);
        watch_no_valid("bad_ctrl_valid", 3);

        run_op("divu",     DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu",     REMU, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div_neg",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem_neg",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("remu_big", REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 34, 0);
        run_op("div_mix",  DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);

        // Flush ten cycles into a DIVU 1000/3.
        drive_start(DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        bus.i_kill = 1'b1;
        @(posedge clk);
        #1;
        bus.i_kill = 1'b0;
        chk("kill_busy", bus.o_busy, 1'b0);
        chk("kill_result", bus.o_result, last_exp);
        watch_no_valid("kill_valid", 40);
        chk("kill_result_hold", bus.o_result, last_exp);

        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_kill  = 1'b1;
        bus.i_ctrl  = DIVU;
        bus.i_dataa = 32'd9;
        bus.i_datab = 32'd3;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_kill  = 1'b0;
        chk("kill_start_busy", bus.o_busy, 1'b0);

        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 34, 0);
        run_op("busy_ign", DIVU, 32'd100, 32'd7, 32'd14, 34, 5);

        // Asynchronous reset in the middle of CALC.
        drive_start(DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.o_busy, 1'b0);
        chk("arst_valid", bus.o_valid, 1'b0);
        chk("arst_result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("arst_no_valid", 40);

        run_op("post_rst", DIVU, 32'd1000, 32'd3, 32'd333, 34, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
